// File: rtl/rf_write_scheduler_pkg.sv
// rf_write_scheduler_pkg: shared constants and types for the register-file write scheduler
package rf_write_scheduler_pkg;
   localparam logic [4:0] LINK_REG = 5'd31;
   localparam int L16B_BEATS = 4;
   typedef enum logic {IDLE, BURST} state_t;
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_entry_t;
endpackage

// File: rtl/rf_write_scheduler_if.sv
// rf_write_scheduler_if: writeback-source, decode-read and register-file bundle
interface rf_write_scheduler_if #(parameter int DEPTH = 8);
   logic                     WB_Valid;
   logic [4:0]               WB_Addr;
   logic [31:0]              WB_Data;
   logic                     JAL_Valid;
   logic [31:0]              JAL_Link;
   logic                     L16B_Valid;
   logic [4:0]               L16B_Addr;
   logic [127:0]             L16B_Data;
   logic [4:0]               RdAddrA;
   logic [4:0]               RdAddrB;
   logic                     RF_WE;
   logic [4:0]               RF_WAddr;
   logic [31:0]              RF_WData;
   logic                     HitA;
   logic                     HitB;
   logic [31:0]              FwdDataA;
   logic [31:0]              FwdDataB;
   logic                     Stall;
   logic                     Overflow;
   logic [$clog2(DEPTH):0]   Count;
   modport master (
      output WB_Valid, WB_Addr, WB_Data, JAL_Valid, JAL_Link,
             L16B_Valid, L16B_Addr, L16B_Data, RdAddrA, RdAddrB,
      input  RF_WE, RF_WAddr, RF_WData, HitA, HitB, FwdDataA, FwdDataB,
             Stall, Overflow, Count
   );
   modport slave (
      input  WB_Valid, WB_Addr, WB_Data, JAL_Valid, JAL_Link,
             L16B_Valid, L16B_Addr, L16B_Data, RdAddrA, RdAddrB,
      output RF_WE, RF_WAddr, RF_WData, HitA, HitB, FwdDataA, FwdDataB,
             Stall, Overflow, Count
   );
endinterface

// File: rtl/rf_write_scheduler_fifo.sv
// wr_queue_fifo: circular write queue with dual enqueue, single dequeue and youngest-match lookup
module wr_queue_fifo
   import rf_write_scheduler_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_a,
   input  wr_entry_t              ent_a,
   input  logic                   push_b,
   input  wr_entry_t              ent_b,
   input  logic                   pop,
   input  logic [4:0]             addr_a,
   input  logic [4:0]             addr_b,
   output wr_entry_t              head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   hit_a,
   output logic                   hit_b,
   output logic [31:0]            data_a,
   output logic [31:0]            data_b
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   wr_entry_t         mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   assign head = mem[rd_ptr];
   // pointer/count bookkeeping; entry b always lands right after entry a
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_a) mem[wr_ptr] <= ent_a;
         if (push_b) mem[wr_ptr + AW'(push_a)] <= ent_b;
         wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
      end
   end
   // walk oldest to youngest so the last match wins
   always_comb begin
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      data_a = '0;
      data_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(count) && mem[rd_ptr + AW'(i)].addr == addr_a) begin
            hit_a  = 1'b1;
            data_a = mem[rd_ptr + AW'(i)].data;
         end
         if (i < int'(count) && mem[rd_ptr + AW'(i)].addr == addr_b) begin
            hit_b  = 1'b1;
            data_b = mem[rd_ptr + AW'(i)].data;
         end
      end
   end
endmodule

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: merges WB, JAL and L16B burst writes into one register-file write port
module rf_write_scheduler
   import rf_write_scheduler_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int STALL_THRESH = 2
) (
   input logic                Clock,
   input logic                Reset,
   rf_write_scheduler_if.slave bus
);
   state_t                 state;
   logic [1:0]             beat;
   logic [4:0]             base;
   logic [127:0]           bdata;
   logic [$clog2(DEPTH):0] count;
   wr_entry_t              head, e0, e1, beat_e, fa, out_e;
   logic                   wb_req, jal_req, beat_go, beat_req;
   logic                   e0v, e1v, bypass, pop, push_a, push_b, drop, out_we;
   logic                   q_hit_a, q_hit_b;
   logic [31:0]            q_data_a, q_data_b;
   int                     free;
   // arbitration: WB, then JAL, then burst beat, two slots per cycle; an empty queue bypasses slot 0 to the output
   always_comb begin
      wb_req      = bus.WB_Valid && bus.WB_Addr != 5'd0;
      jal_req     = bus.JAL_Valid;
      beat_go     = state == BURST && !(wb_req && jal_req);
      beat_e.addr = base + {3'b000, beat};
      beat_e.data = bdata[{beat, 5'd0} +: 32];
      beat_req    = beat_go && beat_e.addr != 5'd0;
      e0v         = wb_req || jal_req || beat_req;
      e1v         = (wb_req && jal_req) || ((wb_req ^ jal_req) && beat_req);
      e0          = wb_req ? wr_entry_t'{bus.WB_Addr, bus.WB_Data}
                  : jal_req ? wr_entry_t'{LINK_REG, bus.JAL_Link} : beat_e;
      e1          = (wb_req && jal_req) ? wr_entry_t'{LINK_REG, bus.JAL_Link} : beat_e;
      bypass      = count == '0;
      pop         = !bypass;
      free        = DEPTH - int'(count) + int'(pop);
      fa          = bypass ? e1 : e0;
      push_a      = (bypass ? e1v : e0v) && free >= 1;
      push_b      = !bypass && e1v && free >= 2;
      drop        = ((bypass ? e1v : e0v) && free < 1) || (!bypass && e1v && free < 2);
      out_we      = bypass ? e0v : 1'b1;
      out_e       = bypass ? e0 : head;
   end
   wr_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (Clock),
      .rst    (Reset),
      .push_a (push_a),
      .ent_a  (fa),
      .push_b (push_b),
      .ent_b  (e1),
      .pop    (pop),
      .addr_a (bus.RdAddrA),
      .addr_b (bus.RdAddrB),
      .head   (head),
      .count  (count),
      .hit_a  (q_hit_a),
      .hit_b  (q_hit_b),
      .data_a (q_data_a),
      .data_b (q_data_b)
   );
   // burst FSM, sticky overflow and the registered register-file write port
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= IDLE;
         beat         <= '0;
         base         <= '0;
         bdata        <= '0;
         bus.Overflow <= 1'b0;
         bus.RF_WE    <= 1'b0;
         bus.RF_WAddr <= '0;
         bus.RF_WData <= '0;
      end else begin
         bus.RF_WE <= out_we;
         if (out_we) begin
            bus.RF_WAddr <= out_e.addr;
            bus.RF_WData <= out_e.data;
         end
         if (drop || (state == BURST && bus.L16B_Valid)) bus.Overflow <= 1'b1;
         if (state == IDLE) begin
            if (bus.L16B_Valid) begin
               state <= BURST;
               base  <= bus.L16B_Addr;
               bdata <= bus.L16B_Data;
               beat  <= '0;
            end
         end else if (beat_go) begin
            beat <= beat + 2'd1;
            if (beat == 2'(L16B_BEATS - 1)) state <= IDLE;
         end
      end
   end
   // stall, occupancy and forwarding; queue contents outrank the output register
   always_comb begin
      bus.Count    = count;
      bus.Stall    = (DEPTH - int'(count) <= STALL_THRESH) || state == BURST || bus.L16B_Valid;
      bus.HitA     = bus.RdAddrA != 5'd0 && (q_hit_a || (bus.RF_WE && bus.RF_WAddr == bus.RdAddrA));
      bus.HitB     = bus.RdAddrB != 5'd0 && (q_hit_b || (bus.RF_WE && bus.RF_WAddr == bus.RdAddrB));
      bus.FwdDataA = !bus.HitA ? '0 : q_hit_a ? q_data_a : bus.RF_WData;
      bus.FwdDataB = !bus.HitB ? '0 : q_hit_b ? q_data_b : bus.RF_WData;
   end
endmodule
